tl_d_channel_arbiter: RTL
=========================

Name: tl_d_channel_arbiter

Overview:
- N-input round-robin arbiter sharing one TileLink D channel (64-bit beats) between several responders, such as cache refill, MMIO and error slaves.
- Feeds a single-entry flow queue toward the core.
- Locks the grant for the whole of a multi-beat data response (AccessAckData, GrantData) so that beats from different responders never interleave.
- Zero-latency combinational path from the granted input to the output; arbitration state is registered.

Parameters:
- N_REQ, 2, number of requesting D-channel inputs (2..8).
- SOURCE_W, 6, width of d_source.
- SINK_W, 3, width of d_sink.
- MAX_SIZE, 6, largest legal log2(bytes) in d_size; sets the maximum burst of 2^(MAX_SIZE-3) beats.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  N_REQ  per-requester beat valid.
- in_ready  out  N_REQ  per-requester beat accepted.
- in_opcode  in  3*N_REQ  packed; requester i occupies [3i+2:3i].
- in_param  in  2*N_REQ  packed.
- in_size  in  3*N_REQ  packed.
- in_source  in  SOURCE_W*N_REQ  packed.
- in_sink  in  SINK_W*N_REQ  packed.
- in_denied  in  N_REQ  per-requester denied bit.
- in_data  in  64*N_REQ  packed.
- in_corrupt  in  N_REQ  per-requester corrupt bit.
- out_ready  in  1  downstream ready.
- out_valid  out  1  output beat valid.
- out_opcode / out_param / out_size / out_source / out_sink / out_denied / out_data / out_corrupt  out  3/2/3/SOURCE_W/SINK_W/1/64/1  granted requester's fields.
- out_grant  out  N_REQ  one-hot grant of the current cycle; zero when nothing is granted.

Behaviour:
- State registers:
  - rr_ptr: log2(N_REQ) bits.
  - locked: 1 bit.
  - lock_id: log2(N_REQ) bits.
  - beats_left: MAX_SIZE-3 bits.
- Reset (asynchronous, active-high) clears every state register to 0.
- While reset is asserted: out_valid=0, in_ready=0, out_grant=0.
- Grant selection, unlocked:
  - Grant the first valid requester found searching upward from rr_ptr, wrapping modulo N_REQ.
  - With no valid requester: out_grant=0 and out_valid=0.
- Grant selection, locked: grant lock_id only.
  - out_valid=in_valid[lock_id].
  - All other in_ready are 0, even when those requesters are valid.
- Output fields are a combinational mux of the granted requester's fields. With no grant, out_data and the other fields are don't-care.
- in_ready[i] = out_grant[i] & out_ready.
- A beat is accepted when out_valid & out_ready.
- Beat count of a message:
  - opcode 1 (AccessAckData) or 5 (GrantData): 2^(size-3) beats when size>3, otherwise 1 beat.
  - All other opcodes: 1 beat.
- First accepted beat of a message with beat count >1:
  - locked<=1, lock_id<=granted index, beats_left<=count-1.
- Each accepted beat while locked decrements beats_left.
- Accepting the beat with beats_left==1 completes the message: locked<=0.
- rr_ptr update: on acceptance of the final beat of any message (single-beat messages included), rr_ptr<=(granted index+1) mod N_REQ. The first-beat fields sample only on unlocked acceptances.
- A requester stalling mid-burst (in_valid low while locked) keeps the lock. out_valid is 0 until it resumes.
- size>MAX_SIZE on a data opcode is illegal: treat it as MAX_SIZE.
- Requesters must hold their fields stable while valid and not ready.
- Reset asserted mid-burst clears the lock immediately. The next cycle after deassertion arbitrates from rr_ptr=0.

Optional Feature:
- Macro: TL_D_ARB_PERF_EN.
- When defined:
  - Adds output perf_grant_cnt, 16*N_REQ bits: per-requester counters of completed messages, incremented on final-beat acceptance, wrapping at 2^16, cleared by reset.
  - Adds output perf_lock_stall, 16 bits: count of cycles where locked=1, out_ready=1 and in_valid[lock_id]=0, saturating at 0xFFFF.
- When undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package tl_d_pkg holds:
  - opcode localparams: ACCESS_ACK=0, ACCESS_ACK_DATA=1, GRANT=4, GRANT_DATA=5, RELEASE_ACK=6.
  - function has_data(opcode).
  - function num_beats(opcode, size, max_size).
  - TL_DATA_BYTES=8.
- One sub-module, rr_pick: a parameterised round-robin priority encoder with inputs req, ptr and outputs a one-hot grant plus an index. Reused by other channel arbiters.

Test Plan:
- Single beats from two requesters: N_REQ=2, both valid every cycle with opcode 0 and out_ready=1 -> grants alternate 0,1,0,1; each in_ready is high on its own grant cycle only.
- Burst lock: req0 AccessAckData size=6 (8 beats), req1 valid throughout -> out_grant=01 for 8 accepted beats with no req1 interleave; req1 granted on the 9th beat; rr_ptr=0 afterwards.
- Backpressure: burst of size 5 with out_ready toggling 1,0,1,0 -> no beat lost or duplicated, beats_left decrements on ready cycles only, 4 beats delivered over 8 cycles.
- Mid-burst stall: req1 GrantData size 4 drops in_valid after beat 1 for 3 cycles while req0 is valid -> out_valid=0 during the stall, req0 is not granted, and the lock releases after beat 2.
- Reset mid-burst: assert reset asynchronously during beat 3 of 8 -> out_valid and in_ready go 0 without waiting for a clock edge; after release a new req1 single beat is granted within 1 cycle.
- Perf (TL_D_ARB_PERF_EN): 3 messages on req0 and 2 on req1 -> perf_grant_cnt={16'd2,16'd3}; a 2-cycle stall during a burst -> perf_lock_stall=2.

Source files
------------

// File: rtl/tl_d_pkg.sv
// tl_d_pkg: TileLink D-channel opcodes and beat-count helpers shared by the channel arbiters.
package tl_d_pkg;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] GRANT           = 3'd4;
  localparam logic [2:0] GRANT_DATA      = 3'd5;
  localparam logic [2:0] RELEASE_ACK     = 3'd6;
  localparam int TL_DATA_BYTES = 8;

  function automatic logic has_data(input logic [2:0] opcode);
    return opcode == ACCESS_ACK_DATA || opcode == GRANT_DATA;
  endfunction

  // Oversized data messages are clamped to max_size rather than rejected.
  function automatic int num_beats(input logic [2:0] opcode, input logic [2:0] size, input int max_size);
    int s;
    s = (int'(size) > max_size) ? max_size : int'(size);
    return (has_data(opcode) && s > 3) ? (1 << (s - 3)) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin priority encoder; first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    grant = (|req) ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/tl_d_channel_arbiter.sv
// tl_d_channel_arbiter: round-robin TileLink D-channel arbiter that locks the grant for multi-beat bursts.
// Defining TL_D_ARB_PERF_EN adds per-requester message counters and a lock-stall counter.
module tl_d_channel_arbiter
  import tl_d_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int SOURCE_W = 6,
  parameter int SINK_W   = 3,
  parameter int MAX_SIZE = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           in_valid,
  output logic [N_REQ-1:0]           in_ready,
  input  logic [3*N_REQ-1:0]         in_opcode,
  input  logic [2*N_REQ-1:0]         in_param,
  input  logic [3*N_REQ-1:0]         in_size,
  input  logic [SOURCE_W*N_REQ-1:0]  in_source,
  input  logic [SINK_W*N_REQ-1:0]    in_sink,
  input  logic [N_REQ-1:0]           in_denied,
  input  logic [64*N_REQ-1:0]        in_data,
  input  logic [N_REQ-1:0]           in_corrupt,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [2:0]                 out_opcode,
  output logic [1:0]                 out_param,
  output logic [2:0]                 out_size,
  output logic [SOURCE_W-1:0]        out_source,
  output logic [SINK_W-1:0]          out_sink,
  output logic                       out_denied,
  output logic [63:0]                out_data,
  output logic                       out_corrupt,
  output logic [N_REQ-1:0]           out_grant
`ifdef TL_D_ARB_PERF_EN
  ,
  output logic [16*N_REQ-1:0]        perf_grant_cnt,
  output logic [15:0]                perf_lock_stall
`endif
);
  localparam int IW = $clog2(N_REQ);
  localparam int BW = (MAX_SIZE > 3) ? MAX_SIZE - 3 : 1;

  logic [IW-1:0]    r_rr_ptr, r_lock_id;
  logic             r_locked;
  logic [BW-1:0]    r_beats_left;
  logic [N_REQ-1:0] w_req, w_pick_grant;
  logic [IW-1:0]    w_idx, w_next;
  logic             w_acc, w_last;
  int               w_cnt;

  // While locked only the owner may compete, so a stalled owner yields no grant at all.
  assign w_req = r_locked ? (in_valid & (N_REQ'(1) << r_lock_id)) : in_valid;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req  (w_req),
    .ptr  (r_rr_ptr),
    .grant(w_pick_grant),
    .idx  (w_idx)
  );

  assign out_grant   = reset ? '0 : w_pick_grant;
  assign out_valid   = |out_grant;
  assign in_ready    = out_ready ? out_grant : '0;
  assign w_acc       = out_valid & out_ready;
  assign out_opcode  = in_opcode[3*w_idx +: 3];
  assign out_param   = in_param[2*w_idx +: 2];
  assign out_size    = in_size[3*w_idx +: 3];
  assign out_source  = in_source[SOURCE_W*w_idx +: SOURCE_W];
  assign out_sink    = in_sink[SINK_W*w_idx +: SINK_W];
  assign out_denied  = in_denied[w_idx];
  assign out_data    = in_data[64*w_idx +: 64];
  assign out_corrupt = in_corrupt[w_idx];
  assign w_cnt       = num_beats(out_opcode, out_size, MAX_SIZE);
  assign w_last      = w_acc & (r_locked ? r_beats_left == BW'(1) : w_cnt == 1);
  assign w_next      = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_rr_ptr     <= '0;
      r_locked     <= 1'b0;
      r_lock_id    <= '0;
      r_beats_left <= '0;
    end else if (w_acc) begin
      if (r_locked) r_beats_left <= r_beats_left - 1'b1;
      else if (w_cnt > 1) begin
        r_locked     <= 1'b1;
        r_lock_id    <= w_idx;
        r_beats_left <= BW'(w_cnt - 1);
      end
      if (w_last) begin
        r_locked <= 1'b0;
        r_rr_ptr <= w_next;
      end
    end

`ifdef TL_D_ARB_PERF_EN
  logic [16*N_REQ-1:0] r_grant_cnt;
  logic [15:0]         r_lock_stall;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_grant_cnt  <= '0;
      r_lock_stall <= '0;
    end else begin
      if (w_last) r_grant_cnt[16*w_idx +: 16] <= r_grant_cnt[16*w_idx +: 16] + 16'd1;
      if (r_locked && out_ready && !in_valid[r_lock_id] && r_lock_stall != 16'hFFFF)
        r_lock_stall <= r_lock_stall + 16'd1;
    end

  assign perf_grant_cnt  = r_grant_cnt;
  assign perf_lock_stall = r_lock_stall;
`endif
endmodule
